mc_ctrl: RTL and testbench

Multi-cycle control sequencer for the RV32I core. Replaces the single-cycle decoder when instruction and data share one memory port. An FSM steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives the existing datapath select/enable signals with the existing encodings. It also handles the memory request/ready handshake, PC update and fault detection.

---
 rtl/mc_pkg.sv | 97 +++++++++
 rtl/mc_decode.sv | 61 ++++++
 rtl/mc_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared types and encodings for the multi-cycle RV32I control sequencer.
// Holds the FSM state enum, instruction classes, opcode constants and the
// datapath select encodings (alu_op, br_type, wb_sel) used by mc_decode and mc_ctrl.
package mc_pkg;

    // FSM states; o_dbg_state in mc_ctrl exposes this directly
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    // Instruction classes produced by the decoder
    typedef enum logic [3:0] {
        C_R       = 4'd0,
        C_I       = 4'd1,
        C_LOAD    = 4'd2,
        C_STORE   = 4'd3,
        C_BRANCH  = 4'd4,
        C_AUIPC   = 4'd5,
        C_LUI     = 4'd6,
        C_JAL     = 4'd7,
        C_JALR    = 4'd8,
        C_ILLEGAL = 4'd9
    } iclass_t;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // The two legal func7 values for R-type and I-type shifts
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // alu_op encodings of the existing datapath
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    // br_type encodings; 6 (always) exists in the datapath but is never
    // generated here because jumps redirect the PC through pc_sel in WB.
    localparam logic [2:0] BR_BEQ   = 3'd0;
    localparam logic [2:0] BR_BNE   = 3'd1;
    localparam logic [2:0] BR_BLT   = 3'd2;
    localparam logic [2:0] BR_BGE   = 3'd3;
    localparam logic [2:0] BR_BLTU  = 3'd4;
    localparam logic [2:0] BR_BGEU  = 3'd5;
    localparam logic [2:0] BR_NEVER = 3'd7;

    // wb_sel encodings
    localparam logic [1:0] WB_PC4 = 2'd0;
    localparam logic [1:0] WB_ALU = 2'd1;
    localparam logic [1:0] WB_MEM = 2'd2;

    // True when func7 is one of the two encodings the base ISA defines
    function automatic logic funct7_ok(input logic [6:0] funct7);
        return (funct7 == F7_BASE) || (funct7 == F7_ALT);
    endfunction

    // func3 -> alu_op for R/I arithmetic. alt is instr[30]; allow_sub is set
    // only for R-type because I-type has no subtract (addi ignores func7).
    function automatic logic [3:0] alu_from_funct3(input logic [2:0] funct3,
                                                   input logic       alt,
                                                   input logic       allow_sub);
        logic [3:0] op;
        case (funct3)
            3'b000:  op = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mc_decode.sv
// mc_decode: purely combinational instruction decoder for mc_ctrl.
// Maps opcode/func3/func7 to an instruction class, the EXEC-phase alu_op,
// the branch br_type and an illegal-encoding flag.
module mc_decode
    import mc_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic [6:0] i_funct7,
    output iclass_t    o_class,
    output logic [3:0] o_alu_op,
    output logic [2:0] o_br_type,
    output logic       o_illegal
);

    // Classify the instruction and derive ALU/branch controls and legality
    always_comb begin
        o_class   = C_ILLEGAL;
        o_alu_op  = ALU_ADD;
        o_br_type = BR_NEVER;
        o_illegal = 1'b0;
        case (i_opcode)
            OP_R: begin
                o_class   = C_R;
                o_alu_op  = alu_from_funct3(i_funct3, i_funct7[5], 1'b1);
                o_illegal = !funct7_ok(i_funct7);
            end
            OP_I: begin
                o_class  = C_I;
                o_alu_op = alu_from_funct3(i_funct3, i_funct7[5], 1'b0);
                // only the shift forms carry meaning in func7
                if ((i_funct3 == 3'b001) || (i_funct3 == 3'b101)) begin
                    o_illegal = !funct7_ok(i_funct7);
                end
            end
            OP_LOAD:  o_class = C_LOAD;
            OP_STORE: o_class = C_STORE;
            OP_BRANCH: begin
                o_class = C_BRANCH;
                case (i_funct3)
                    3'b000:  o_br_type = BR_BEQ;
                    3'b001:  o_br_type = BR_BNE;
                    3'b100:  o_br_type = BR_BLT;
                    3'b101:  o_br_type = BR_BGE;
                    3'b110:  o_br_type = BR_BLTU;
                    3'b111:  o_br_type = BR_BGEU;
                    default: o_illegal = 1'b1;
                endcase
            end
            OP_AUIPC: o_class = C_AUIPC;
            OP_LUI: begin
                o_class  = C_LUI;
                o_alu_op = ALU_AND;
            end
            OP_JAL:  o_class = C_JAL;
            OP_JALR: o_class = C_JALR;
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control sequencer for the RV32I core with a shared
// instruction/data memory port. Steps each instruction through
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and drives the datapath controls.
// Optional feature macro MC_MEM_TIMEOUT_EN: bounds every memory wait to
// TIMEOUT cycles (TIMEOUT >= 1) and faults when the bound is hit.
// Memory handshake: a transfer completes in the cycle where mem_req and
// mem_ready are both 1; mem_req stays high until then and mem_ready seen
// without mem_req has no effect.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        br_taken,
    output logic        ir_wr,
    output logic        alu_out_wr,
    output logic        pc_wr,
    output logic        pc_sel,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  alu_op,
    output logic        sel_A,
    output logic        sel_B,
    output logic        reg_wr,
    output logic [1:0]  wb_sel,
    output logic [2:0]  br_type,
    output logic        retire,
    output logic        fault,
    output state_t      o_dbg_state
);

    state_t     r_state;
    state_t     w_state_next;
    iclass_t    w_class;
    logic [3:0] w_alu_op;
    logic [2:0] w_br_type;
    logic       w_illegal;
    logic       w_timeout_hit;
    logic       w_unused_instr;

    // register numbers and immediates are consumed by the datapath, not here
    assign w_unused_instr = ^{instr[24:15], instr[11:7]};

    mc_decode u_decode (
        .i_opcode  (instr[6:0]),
        .i_funct3  (instr[14:12]),
        .i_funct7  (instr[31:25]),
        .o_class   (w_class),
        .o_alu_op  (w_alu_op),
        .o_br_type (w_br_type),
        .o_illegal (w_illegal)
    );

`ifdef MC_MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_wait_cnt;
    logic             w_mem_phase;

    assign w_mem_phase   = (r_state == S_FETCH) || (r_state == S_MEM);
    assign w_timeout_hit = (r_wait_cnt == CNT_W'(TIMEOUT));

    // Count wait cycles of the open request; zero outside FETCH/MEM and after a handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (!w_mem_phase || mem_ready) begin
            r_wait_cnt <= '0;
        end else if (!w_timeout_hit) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end
    end
`else
    // waits are unbounded; TIMEOUT has no effect in this build
    assign w_timeout_hit = 1'b0 & (TIMEOUT != 0);
`endif

    // State register; reset parks the sequencer in IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign o_dbg_state = r_state;

    // Next-state and Moore/Mealy control outputs for the current phase
    always_comb begin
        w_state_next = r_state;
        ir_wr        = 1'b0;
        alu_out_wr   = 1'b0;
        pc_wr        = 1'b0;
        pc_sel       = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        alu_op       = ALU_ADD;
        sel_A        = 1'b0;
        sel_B        = 1'b0;
        reg_wr       = 1'b0;
        wb_sel       = WB_PC4;
        br_type      = BR_NEVER;
        retire       = 1'b0;
        fault        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_next = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_wr        = 1'b1;
                    w_state_next = S_DECODE;
                end else if (w_timeout_hit) begin
                    w_state_next = S_FAULT;
                end
            end
            S_DECODE: begin
                w_state_next = w_illegal ? S_FAULT : S_EXEC;
            end
            S_EXEC: begin
                alu_out_wr   = 1'b1;
                alu_op       = w_alu_op;
                br_type      = w_br_type;
                w_state_next = S_WB;
                case (w_class)
                    C_R: begin
                        sel_A = 1'b0;
                        sel_B = 1'b0;
                    end
                    C_LOAD, C_STORE: begin
                        sel_B        = 1'b1;
                        w_state_next = S_MEM;
                    end
                    C_AUIPC, C_JAL: begin
                        sel_A = 1'b1;
                        sel_B = 1'b1;
                    end
                    C_BRANCH: begin
                        // ALU forms the target PC+imm; the comparator picks it
                        sel_A        = 1'b1;
                        sel_B        = 1'b1;
                        pc_wr        = 1'b1;
                        pc_sel       = br_taken;
                        retire       = 1'b1;
                        w_state_next = S_FETCH;
                    end
                    default: begin
                        // I-type, LUI and JALR all take the immediate on B
                        sel_B = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (w_class == C_STORE);
                if (mem_ready) begin
                    if (w_class == C_STORE) begin
                        pc_wr        = 1'b1;
                        pc_sel       = 1'b0;
                        retire       = 1'b1;
                        w_state_next = S_FETCH;
                    end else begin
                        w_state_next = S_WB;
                    end
                end else if (w_timeout_hit) begin
                    w_state_next = S_FAULT;
                end
            end
            S_WB: begin
                reg_wr       = 1'b1;
                pc_wr        = 1'b1;
                retire       = 1'b1;
                w_state_next = S_FETCH;
                case (w_class)
                    C_LOAD: begin
                        wb_sel = WB_MEM;
                    end
                    C_JAL, C_JALR: begin
                        wb_sel = WB_PC4;
                        pc_sel = 1'b1;
                    end
                    default: begin
                        wb_sel = WB_ALU;
                        pc_sel = 1'b0;
                    end
                endcase
            end
            S_FAULT: begin
                fault        = 1'b1;
                w_state_next = S_FAULT;
            end
            default: begin
                w_state_next = S_FAULT;
            end
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed-vector bench for mc_ctrl. Inputs change on the falling
// edge and outputs are sampled 1 ns later; every expected control word is
// written out by hand below.
module tb_mc_ctrl;
    import mc_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = 32'h0;
    logic        mem_ready = 1'b0;
    logic        br_taken = 1'b0;

    logic        ir_wr, alu_out_wr, pc_wr, pc_sel, mem_req, mem_we;
    logic [3:0]  alu_op;
    logic        sel_A, sel_B, reg_wr;
    logic [1:0]  wb_sel;
    logic [2:0]  br_type;
    logic        retire, fault;
    state_t      dbg_state;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mc_ctrl #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .mem_ready   (mem_ready),
        .br_taken    (br_taken),
        .ir_wr       (ir_wr),
        .alu_out_wr  (alu_out_wr),
        .pc_wr       (pc_wr),
        .pc_sel      (pc_sel),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .alu_op      (alu_op),
        .sel_A       (sel_A),
        .sel_B       (sel_B),
        .reg_wr      (reg_wr),
        .wb_sel      (wb_sel),
        .br_type     (br_type),
        .retire      (retire),
        .fault       (fault),
        .o_dbg_state (dbg_state)
    );

    // control word: {ir_wr,alu_out_wr,pc_wr,pc_sel,mem_req,mem_we,alu_op[3:0],
    //                sel_A,sel_B,reg_wr,wb_sel[1:0],br_type[2:0],retire,fault}
    logic [18:0] ctl;
    assign ctl = {ir_wr, alu_out_wr, pc_wr, pc_sel, mem_req, mem_we, alu_op,
                  sel_A, sel_B, reg_wr, wb_sel, br_type, retire, fault};

    function automatic logic [18:0] mk(int ir, int aw, int pw, int ps, int mr, int mw,
                                       int op, int sa, int sb, int rw, int ws, int bt,
                                       int rt, int ft);
        return {1'(ir), 1'(aw), 1'(pw), 1'(ps), 1'(mr), 1'(mw), 4'(op),
                1'(sa), 1'(sb), 1'(rw), 2'(ws), 3'(bt), 1'(rt), 1'(ft)};
    endfunction

    localparam logic [18:0] V_ZERO      = mk(0,0,0,0,0,0, 0,0,0,0,0,7,0,0);
    localparam logic [18:0] V_FETCH_W   = mk(0,0,0,0,1,0, 0,0,0,0,0,7,0,0);
    localparam logic [18:0] V_FETCH_OK  = mk(1,0,0,0,1,0, 0,0,0,0,0,7,0,0);
    localparam logic [18:0] V_FAULT     = mk(0,0,0,0,0,0, 0,0,0,0,0,7,0,1);
    localparam logic [18:0] V_EX_ADDR   = mk(0,1,0,0,0,0, 0,0,1,0,0,7,0,0);
    localparam logic [18:0] V_MEM_RD    = mk(0,0,0,0,1,0, 0,0,0,0,0,7,0,0);
    localparam logic [18:0] V_MEM_ST    = mk(0,0,1,0,1,1, 0,0,0,0,0,7,1,0);
    localparam logic [18:0] V_WB_ALU    = mk(0,0,1,0,0,0, 0,0,0,1,1,7,1,0);
    localparam logic [18:0] V_WB_LOAD   = mk(0,0,1,0,0,0, 0,0,0,1,2,7,1,0);
    localparam logic [18:0] V_WB_JUMP   = mk(0,0,1,1,0,0, 0,0,0,1,0,7,1,0);

    typedef struct {
        logic [31:0] ins;
        logic [18:0] ex;
        logic [18:0] wb;
    } alu_vec_t;

    typedef struct {
        logic [31:0] ins;
        logic        tkn;
        int          bt;
    } br_vec_t;

    // ---------------- driver tasks ----------------
    task automatic step(input logic rdy, input logic tkn);
        @(negedge clk);
        mem_ready = rdy;
        br_taken  = tkn;
        #1;
    endtask

    // leaves the DUT in IDLE, 1 ns after a falling edge
    task automatic do_reset(input logic [31:0] ins);
        @(negedge clk);
        rst       = 1'b1;
        mem_ready = 1'b0;
        br_taken  = 1'b0;
        instr     = ins;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        #1;
        if (dbg_state !== S_IDLE || ctl !== V_ZERO) begin
            $display("FAIL reset_active state=%0d ctl=%h expected state=%0d ctl=%h",
                     dbg_state, ctl, S_IDLE, V_ZERO);
            failures++;
        end
        checks++;
        rst = 1'b0;
        #1;
        if (dbg_state !== S_IDLE || ctl !== V_ZERO) begin
            $display("FAIL reset_release state=%0d ctl=%h expected state=%0d ctl=%h",
                     dbg_state, ctl, S_IDLE, V_ZERO);
            failures++;
        end
        checks++;
        for (int c = 0; c < 2; c++) begin
            step(1'b0, 1'b0);
            if (dbg_state !== S_FETCH || ctl !== V_FETCH_W) begin
                $display("FAIL first_fetch cyc%0d state=%0d ctl=%h expected state=%0d ctl=%h",
                         c + 1, dbg_state, ctl, S_FETCH, V_FETCH_W);
                failures++;
            end
            checks++;
        end
    endtask

    task automatic test_addi();
        state_t      es[5];
        logic [18:0] ev[5];
        es = '{S_FETCH, S_DECODE, S_EXEC, S_WB, S_FETCH};
        ev = '{V_FETCH_OK, V_ZERO, V_EX_ADDR, V_WB_ALU, V_FETCH_OK};
        do_reset(32'h00500093);
        for (int c = 0; c < 5; c++) begin
            step(1'b1, 1'b0);
            if (dbg_state !== es[c] || ctl !== ev[c]) begin
                $display("FAIL addi cyc%0d state=%0d ctl=%h expected state=%0d ctl=%h",
                         c + 1, dbg_state, ctl, es[c], ev[c]);
                failures++;
            end
            checks++;
        end
    endtask

    task automatic test_load_wait();
        state_t      es[8];
        logic [18:0] ev[8];
        logic        rdy[8];
        es  = '{S_FETCH, S_DECODE, S_EXEC, S_MEM, S_MEM, S_MEM, S_WB, S_FETCH};
        ev  = '{V_FETCH_OK, V_ZERO, V_EX_ADDR, V_MEM_RD, V_MEM_RD, V_MEM_RD, V_WB_LOAD, V_FETCH_OK};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        do_reset(32'h0000A103);
        for (int c = 0; c < 8; c++) begin
            step(rdy[c], 1'b0);
            if (dbg_state !== es[c] || ctl !== ev[c]) begin
                $display("FAIL lw_wait cyc%0d state=%0d ctl=%h expected state=%0d ctl=%h",
                         c + 1, dbg_state, ctl, es[c], ev[c]);
                failures++;
            end
            checks++;
        end
    endtask

    task automatic test_store();
        state_t      es[5];
        logic [18:0] ev[5];
        es = '{S_FETCH, S_DECODE, S_EXEC, S_MEM, S_FETCH};
        ev = '{V_FETCH_OK, V_ZERO, V_EX_ADDR, V_MEM_ST, V_FETCH_OK};
        do_reset(32'h0020A223);
        for (int c = 0; c < 5; c++) begin
            step(1'b1, 1'b0);
            if (dbg_state !== es[c] || ctl !== ev[c]) begin
                $display("FAIL sw cyc%0d state=%0d ctl=%h expected state=%0d ctl=%h",
                         c + 1, dbg_state, ctl, es[c], ev[c]);
                failures++;
            end
            checks++;
        end
    endtask

    task automatic test_exec_wb();
        alu_vec_t tv[10];
        tv = '{
            '{32'hFFF00093, mk(0,1,0,0,0,0, 0,0,1,0,0,7,0,0), V_WB_ALU},   // addi -1, func7 ignored
            '{32'h402081B3, mk(0,1,0,0,0,0, 1,0,0,0,0,7,0,0), V_WB_ALU},   // sub
            '{32'h0020D0B3, mk(0,1,0,0,0,0, 6,0,0,0,0,7,0,0), V_WB_ALU},   // srl
            '{32'h0020F0B3, mk(0,1,0,0,0,0, 9,0,0,0,0,7,0,0), V_WB_ALU},   // and
            '{32'h4030D093, mk(0,1,0,0,0,0, 7,0,1,0,0,7,0,0), V_WB_ALU},   // srai
            '{32'hFFF0B093, mk(0,1,0,0,0,0, 4,0,1,0,0,7,0,0), V_WB_ALU},   // sltiu -1
            '{32'h123450B7, mk(0,1,0,0,0,0, 9,0,1,0,0,7,0,0), V_WB_ALU},   // lui
            '{32'h00000097, mk(0,1,0,0,0,0, 0,1,1,0,0,7,0,0), V_WB_ALU},   // auipc
            '{32'h008000EF, mk(0,1,0,0,0,0, 0,1,1,0,0,7,0,0), V_WB_JUMP},  // jal
            '{32'h000100E7, mk(0,1,0,0,0,0, 0,0,1,0,0,7,0,0), V_WB_JUMP}   // jalr
        };
        foreach (tv[i]) begin
            do_reset(tv[i].ins);
            step(1'b1, 1'b0);
            step(1'b1, 1'b0);
            step(1'b1, 1'b0);
            if (dbg_state !== S_EXEC || ctl !== tv[i].ex) begin
                $display("FAIL exec_%h state=%0d ctl=%h expected state=%0d ctl=%h",
                         tv[i].ins, dbg_state, ctl, S_EXEC, tv[i].ex);
                failures++;
            end
            checks++;
            step(1'b1, 1'b0);
            if (dbg_state !== S_WB || ctl !== tv[i].wb) begin
                $display("FAIL wb_%h state=%0d ctl=%h expected state=%0d ctl=%h",
                         tv[i].ins, dbg_state, ctl, S_WB, tv[i].wb);
                failures++;
            end
            checks++;
        end
    endtask

    task automatic test_branch();
        br_vec_t     tv[5];
        logic [18:0] exp_ex;
        tv = '{
            '{32'h00000463, 1'b1, 0},   // beq taken
            '{32'h00000463, 1'b0, 0},   // beq not taken
            '{32'h00001463, 1'b1, 1},   // bne
            '{32'h00004463, 1'b1, 2},   // blt
            '{32'h00007463, 1'b0, 5}    // bgeu
        };
        foreach (tv[i]) begin
            exp_ex = mk(0,1,1,int'(tv[i].tkn),0,0, 0,1,1,0,0,tv[i].bt,1,0);
            do_reset(tv[i].ins);
            step(1'b1, tv[i].tkn);
            step(1'b1, tv[i].tkn);
            step(1'b1, tv[i].tkn);
            if (dbg_state !== S_EXEC || ctl !== exp_ex) begin
                $display("FAIL branch_%h_t%0d state=%0d ctl=%h expected state=%0d ctl=%h",
                         tv[i].ins, tv[i].tkn, dbg_state, ctl, S_EXEC, exp_ex);
                failures++;
            end
            checks++;
            step(1'b1, tv[i].tkn);
            if (dbg_state !== S_FETCH || ctl !== V_FETCH_OK) begin
                $display("FAIL branch_next_%h state=%0d ctl=%h expected state=%0d ctl=%h",
                         tv[i].ins, dbg_state, ctl, S_FETCH, V_FETCH_OK);
                failures++;
            end
            checks++;
        end
    endtask

    task automatic test_illegal();
        logic [31:0] tv[6];
        tv = '{32'h00000000, 32'h02208033, 32'h02109093, 32'h0000007F,
               32'h00002463, 32'h00003463};
        foreach (tv[i]) begin
            do_reset(tv[i]);
            step(1'b1, 1'b0);
            step(1'b1, 1'b0);
            if (dbg_state !== S_DECODE || ctl !== V_ZERO) begin
                $display("FAIL illegal_decode_%h state=%0d ctl=%h expected state=%0d ctl=%h",
                         tv[i], dbg_state, ctl, S_DECODE, V_ZERO);
                failures++;
            end
            checks++;
            step(1'b1, 1'b0);
            if (dbg_state !== S_FAULT || ctl !== V_FAULT) begin
                $display("FAIL illegal_fault_%h state=%0d ctl=%h expected state=%0d ctl=%h",
                         tv[i], dbg_state, ctl, S_FAULT, V_FAULT);
                failures++;
            end
            checks++;
        end
    endtask

    task automatic test_fault_sticky();
        int bad;
        bad = 0;
        do_reset(32'h00000000);
        for (int c = 0; c < 3; c++) step(1'b1, 1'b0);
        for (int c = 0; c < 30; c++) begin
            step(c[0], c[1]);
            if (dbg_state !== S_FAULT || ctl !== V_FAULT) bad++;
        end
        if (bad != 0) begin
            $display("FAIL fault_sticky bad_cycles=%0d expected 0", bad);
            failures++;
        end
        checks++;
        @(negedge clk);
        rst = 1'b1;
        #1;
        if (dbg_state !== S_IDLE || ctl !== V_ZERO) begin
            $display("FAIL fault_clear state=%0d ctl=%h expected state=%0d ctl=%h",
                     dbg_state, ctl, S_IDLE, V_ZERO);
            failures++;
        end
        checks++;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset_mid();
        do_reset(32'h0000A103);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        if (dbg_state !== S_MEM || ctl !== V_MEM_RD) begin
            $display("FAIL mid_pre state=%0d ctl=%h expected state=%0d ctl=%h",
                     dbg_state, ctl, S_MEM, V_MEM_RD);
            failures++;
        end
        checks++;
        #2;
        rst = 1'b1;
        #1;
        if (dbg_state !== S_IDLE || ctl !== V_ZERO) begin
            $display("FAIL mid_async state=%0d ctl=%h expected state=%0d ctl=%h",
                     dbg_state, ctl, S_IDLE, V_ZERO);
            failures++;
        end
        checks++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        step(1'b1, 1'b0);
        if (dbg_state !== S_FETCH || ctl !== V_FETCH_OK) begin
            $display("FAIL mid_restart state=%0d ctl=%h expected state=%0d ctl=%h",
                     dbg_state, ctl, S_FETCH, V_FETCH_OK);
            failures++;
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        int n_ret;
        n_ret = 0;
        do_reset(32'h00500093);
        for (int c = 1; c <= 9; c++) begin
            step(1'b1, 1'b0);
            if (retire === 1'b1) n_ret++;
            if (c == 5) begin
                if (dbg_state !== S_FETCH || ctl !== V_FETCH_OK) begin
                    $display("FAIL b2b_fetch2 state=%0d ctl=%h expected state=%0d ctl=%h",
                             dbg_state, ctl, S_FETCH, V_FETCH_OK);
                    failures++;
                end
                checks++;
                instr = 32'h0020A223;
            end
            if (c == 8) begin
                if (dbg_state !== S_MEM || ctl !== V_MEM_ST) begin
                    $display("FAIL b2b_store state=%0d ctl=%h expected state=%0d ctl=%h",
                             dbg_state, ctl, S_MEM, V_MEM_ST);
                    failures++;
                end
                checks++;
            end
        end
        if (n_ret != 2) begin
            $display("FAIL b2b_retires got=%0d expected 2", n_ret);
            failures++;
        end
        checks++;
    endtask

    task automatic test_timeout();
`ifdef MC_MEM_TIMEOUT_EN
        // fetch never answered: 5 FETCH cycles (count 0..4), then FAULT
        do_reset(32'h00500093);
        for (int c = 0; c < 5; c++) begin
            step(1'b0, 1'b0);
            if (dbg_state !== S_FETCH || ctl !== V_FETCH_W) begin
                $display("FAIL to_fetch_wait cyc%0d state=%0d ctl=%h expected state=%0d",
                         c + 1, dbg_state, ctl, S_FETCH);
                failures++;
            end
            checks++;
        end
        step(1'b0, 1'b0);
        if (dbg_state !== S_FAULT || ctl !== V_FAULT) begin
            $display("FAIL to_fetch_fault state=%0d ctl=%h expected state=%0d ctl=%h",
                     dbg_state, ctl, S_FAULT, V_FAULT);
            failures++;
        end
        checks++;
        // ready arrives in the limit cycle: transfer completes normally
        do_reset(32'h00500093);
        for (int c = 0; c < 4; c++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        if (dbg_state !== S_DECODE) begin
            $display("FAIL to_limit_ready state=%0d expected state=%0d", dbg_state, S_DECODE);
            failures++;
        end
        checks++;
        // store never answered in MEM
        do_reset(32'h0020A223);
        for (int c = 0; c < 3; c++) step(1'b1, 1'b0);
        for (int c = 0; c < 5; c++) step(1'b0, 1'b0);
        if (dbg_state !== S_MEM) begin
            $display("FAIL to_mem_wait state=%0d expected state=%0d", dbg_state, S_MEM);
            failures++;
        end
        checks++;
        step(1'b0, 1'b0);
        if (dbg_state !== S_FAULT || ctl !== V_FAULT) begin
            $display("FAIL to_mem_fault state=%0d ctl=%h expected state=%0d ctl=%h",
                     dbg_state, ctl, S_FAULT, V_FAULT);
            failures++;
        end
        checks++;
`else
        int bad;
        bad = 0;
        do_reset(32'h00500093);
        for (int c = 0; c < 100; c++) begin
            step(1'b0, 1'b0);
            if (dbg_state !== S_FETCH || ctl !== V_FETCH_W) bad++;
        end
        if (bad != 0) begin
            $display("FAIL no_timeout_wait bad_cycles=%0d expected 0", bad);
            failures++;
        end
        checks++;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        if (dbg_state !== S_DECODE || ctl !== V_ZERO) begin
            $display("FAIL no_timeout_resume state=%0d ctl=%h expected state=%0d ctl=%h",
                     dbg_state, ctl, S_DECODE, V_ZERO);
            failures++;
        end
        checks++;
`endif
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_addi();
        test_load_wait();
        test_store();
        test_exec_wb();
        test_branch();
        test_illegal();
        test_fault_sticky();
        test_reset_mid();
        test_back_to_back();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
